// File: rtl/oflow_mem_buffer_read_client_pkg.sv
// Shared types and constants for the MEM buffer read client.
//   rd_client_state_t : read-client FSM states
//   LINES_CNT_W       : width of the processed-lines counter
//   lines_sat_inc     : saturating increment for the lines counter
package oflow_mem_buffer_read_client_pkg;

  localparam int LINES_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    COMPUTE   = 3'd3,
    ADVANCE   = 3'd4,
    FINISH    = 3'd5
  } rd_client_state_t;

  function automatic logic [LINES_CNT_W-1:0] lines_sat_inc(input logic [LINES_CNT_W-1:0] v);
    return (v == '1) ? v : v + LINES_CNT_W'(1);
  endfunction

endpackage

// File: rtl/oflow_defines_mem_buffer.sv
// MEM buffer width defines shared by the oflow buffer clients.
//   NUM_OF_HISTORY_FRAMES_WIDTH : width of the history-depth field
//   TOTAL_FRAME_NUM_WIDTH       : width of a frame index
`ifndef OFLOW_DEFINES_MEM_BUFFER_SV
`define OFLOW_DEFINES_MEM_BUFFER_SV

`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 4
`endif

`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 5
`endif

`endif

// File: rtl/oflow_read_client_watchdog.sv
// Watchdog for the read client's COMPUTE wait.
// Counts consecutive cycles with run=1 and kick=0; expired is asserted
// combinationally on the TIMEOUT_CYC-th such cycle.
//   clk, reset : clock, synchronous active-high reset
//   run        : FSM is waiting (COMPUTE)
//   kick       : the awaited event arrived this cycle
//   expired    : this is the TIMEOUT_CYC-th consecutive un-kicked cycle
module oflow_read_client_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = run && !kick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || !run || kick) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/oflow_fsm_mem_buffer_read_client.sv
// Read client FSM: scans history lines out of the MEM buffer and hands each
// one to the similarity engine.
// Optional feature: define OFLOW_READ_CLIENT_TIMEOUT_EN to add the COMPUTE
// watchdog and the sticky timeout_err output.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start_compare     : request a history scan (honoured only in IDLE)
//   num_of_history_frames : scan depth; 0 finishes immediately
//   done_read         : buffer issued its last line (latched during a scan)
//   frame_to_read     : frame currently addressed by the buffer
//   start_read        : 1-cycle pulse, starts the buffer read sequence
//   similarity_metric_flag_ready_to_read_new_line : 1-cycle pulse, next line
//   sm_start / sm_done: similarity engine handshake
//   sm_frame          : frame_to_read captured when sm_start fires
//   compare_done      : 1-cycle pulse at scan end
//   busy              : FSM not in IDLE
//   lines_cnt         : lines processed in the current scan (saturating)
//   timeout_err       : (feature only) sticky watchdog error
`ifndef TOTAL_FRAME_NUM_WIDTH
`include "oflow_defines_mem_buffer.sv"
`endif

module oflow_fsm_mem_buffer_read_client
  import oflow_mem_buffer_read_client_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start_compare,
  input  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic                                    done_read,
  input  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_read,
  output logic                                    start_read,
  output logic                                    similarity_metric_flag_ready_to_read_new_line,
  output logic                                    sm_start,
  input  logic                                    sm_done,
  output logic [`TOTAL_FRAME_NUM_WIDTH-1:0]       sm_frame,
  output logic                                    compare_done,
  output logic                                    busy,
  output logic [LINES_CNT_W-1:0]                  lines_cnt
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
  ,
  output logic                                    timeout_err
`endif
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  rd_client_state_t state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             done_latch;
  logic             done_seen;
  logic             scan_active;

  assign done_seen   = done_latch | done_read;
  assign scan_active = (state == WAIT_DATA) || (state == COMPUTE) || (state == ADVANCE);

`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
  logic wd_expired;

  oflow_read_client_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (state == COMPUTE),
    .kick    (sm_done),
    .expired (wd_expired)
  );
`else
  // COMPUTE waits indefinitely; TIMEOUT_CYC has no effect in this build.
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_compare) begin
          state_nxt = (num_of_history_frames != '0) ? REQ : FINISH;
        end
      end
      REQ:       state_nxt = WAIT_DATA;
      WAIT_DATA: if (lat_cnt == LAT_LAST) state_nxt = COMPUTE;
      COMPUTE: begin
        if (sm_done) begin
          state_nxt = ADVANCE;
        end
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt = FINISH;
        end
`endif
      end
      // The new-line pulse was already decided from done_seen on entry, and
      // done_latch holds exactly that value here, so both stay consistent.
      ADVANCE:   state_nxt = done_latch ? FINISH : WAIT_DATA;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // All handshake outputs are registered from the next state so each pulse
  // lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      done_latch   <= 1'b0;
      start_read   <= 1'b0;
      similarity_metric_flag_ready_to_read_new_line <= 1'b0;
      sm_start     <= 1'b0;
      sm_frame     <= '0;
      compare_done <= 1'b0;
      busy         <= 1'b0;
      lines_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      start_read   <= (state_nxt == REQ);
      similarity_metric_flag_ready_to_read_new_line <=
        (state == COMPUTE) && (state_nxt == ADVANCE) && !done_seen;
      sm_start     <= (state == WAIT_DATA) && (state_nxt == COMPUTE);
      compare_done <= (state_nxt == FINISH);
      busy         <= (state_nxt != IDLE);

      if ((state == WAIT_DATA) && (state_nxt == COMPUTE)) begin
        sm_frame <= frame_to_read;
      end

      if (state == WAIT_DATA) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end

      if ((state == IDLE) && (state_nxt == REQ)) begin
        lines_cnt <= '0;
      end else if ((state == COMPUTE) && sm_done) begin
        lines_cnt <= lines_sat_inc(lines_cnt);
      end

      if (state == FINISH) begin
        done_latch <= 1'b0;
      end else if (scan_active && done_read) begin
        done_latch <= 1'b1;
      end
    end
  end

`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if ((state == IDLE) && start_compare) begin
      timeout_err <= 1'b0;
    end else if ((state == COMPUTE) && !sm_done && wd_expired) begin
      timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_oflow_fsm_mem_buffer_read_client.sv
`ifndef TOTAL_FRAME_NUM_WIDTH
`include "oflow_defines_mem_buffer.sv"
`endif

module tb_oflow_fsm_mem_buffer_read_client;

  localparam int TB_MEM_LAT = 2;
  localparam int TB_TIMEOUT = 8;
  localparam int FW  = `TOTAL_FRAME_NUM_WIDTH;
  localparam int NHW = `NUM_OF_HISTORY_FRAMES_WIDTH;

  logic           clk = 1'b0;
  logic           reset;
  logic           start_compare;
  logic [NHW-1:0] num_of_history_frames;
  logic           done_read;
  logic [FW-1:0]  frame_to_read;
  logic           start_read;
  logic           new_line;
  logic           sm_start;
  logic           sm_done;
  logic [FW-1:0]  sm_frame;
  logic           compare_done;
  logic           busy;
  logic [15:0]    lines_cnt;
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
  logic           timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int sr_cnt = 0, nl_cnt = 0, ss_cnt = 0, cd_cnt = 0, excl_viol = 0;

  oflow_fsm_mem_buffer_read_client #(
    .MEM_LAT     (TB_MEM_LAT),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start_compare         (start_compare),
    .num_of_history_frames (num_of_history_frames),
    .done_read             (done_read),
    .frame_to_read         (frame_to_read),
    .start_read            (start_read),
    .similarity_metric_flag_ready_to_read_new_line (new_line),
    .sm_start              (sm_start),
    .sm_done               (sm_done),
    .sm_frame              (sm_frame),
    .compare_done          (compare_done),
    .busy                  (busy),
    .lines_cnt             (lines_cnt)
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
    ,
    .timeout_err           (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Pulse accounting: values sampled here are those of the cycle just ending.
  always @(posedge clk) begin
    if (start_read)   sr_cnt++;
    if (new_line)     nl_cnt++;
    if (sm_start)     ss_cnt++;
    if (compare_done) cd_cnt++;
    if (int'(start_read) + int'(new_line) + int'(sm_start) + int'(compare_done) > 1)
      excl_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan of n_lines lines. Expected behaviour: one start_read, one
  // sm_start per line MEM_LAT+1 cycles after its read pulse, a new-line pulse
  // after every line except the last, lines_cnt = lines so far, compare_done
  // two cycles after the last sm_done.
  task automatic run_scan(input int n_lines, input int depth, input bit same_cycle,
                          input bit poke_start);
    int sr0, nl0, ss0, cd0, k, d;
    logic [FW-1:0] frame;
    bit last;
    sr0 = sr_cnt; nl0 = nl_cnt; ss0 = ss_cnt; cd0 = cd_cnt;
    num_of_history_frames = NHW'(depth);
    start_compare = 1'b1;
    tick();
    start_compare = 1'b0;
    check("scan_start_read", start_read, 1);
    check("scan_busy", busy, 1);
    check("scan_lines_clear", lines_cnt, 0);
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
    check("timeout_err_cleared", timeout_err, 0);
`endif
    for (int i = 1; i <= n_lines; i++) begin
      last = (i == n_lines);
      frame = FW'($urandom);
      frame_to_read = frame;
      k = 0;
      while (sm_start !== 1'b1 && k < 40) begin
        sm_done       = 1'($urandom_range(0, 1));   // must be ignored here
        done_read     = last && !same_cycle && (k == 1);
        start_compare = poke_start && (k == 1);     // must be ignored here
        tick();
        k++;
      end
      sm_done = 1'b0; done_read = 1'b0; start_compare = 1'b0;
      check("sm_start_latency", k, TB_MEM_LAT + 1);
      check("sm_frame", sm_frame, frame);
      frame_to_read = FW'($urandom);
      d = $urandom_range(0, 3);
      repeat (d) tick();
      check("lines_cnt_before_done", lines_cnt, i - 1);
      sm_done   = 1'b1;
      done_read = last && same_cycle;
      tick();
      sm_done = 1'b0; done_read = 1'b0;
      check("lines_cnt", lines_cnt, i);
      check("new_line_pulse", new_line, last ? 0 : 1);
    end
    tick();
    check("compare_done", compare_done, 1);
    check("busy_in_finish", busy, 1);
    tick();
    check("busy_after_scan", busy, 0);
    check("compare_done_one_cycle", compare_done, 0);
    repeat (3) tick();
    check("no_queued_start", busy, 0);
    check("start_read_count", sr_cnt - sr0, 1);
    check("new_line_count", nl_cnt - nl0, n_lines - 1);
    check("sm_start_count", ss_cnt - ss0, n_lines);
    check("compare_done_count", cd_cnt - cd0, 1);
  endtask

  initial begin
    int cd0, sr0, k;
    reset = 1'b1;
    start_compare = 1'b0;
    num_of_history_frames = '0;
    done_read = 1'b0;
    frame_to_read = '0;
    sm_done = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_lines_cnt", lines_cnt, 0);
    check("reset_pulses", {start_read, new_line, sm_start, compare_done}, 0);
    check("reset_sm_frame", sm_frame, 0);
`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
    check("reset_timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    tick();

    // Nominal scan: depth 3, done_read arrives during the 4th line.
    run_scan(4, 3, 1'b0, 1'b0);

    // Zero depth: straight to FINISH.
    sr0 = sr_cnt;
    num_of_history_frames = '0;
    start_compare = 1'b1;
    tick();
    start_compare = 1'b0;
    check("zero_depth_compare_done", compare_done, 1);
    check("zero_depth_start_read", start_read, 0);
    tick();
    check("zero_depth_idle", busy, 0);
    check("zero_depth_no_read", sr_cnt - sr0, 0);

    // done_read and sm_done in the same cycle.
    run_scan(3, 5, 1'b1, 1'b0);
    run_scan(1, 1, 1'b1, 1'b0);

    // start_compare while busy is ignored.
    run_scan(3, 2, 1'b0, 1'b1);

    // Mid-scan reset during COMPUTE.
    cd0 = cd_cnt;
    num_of_history_frames = NHW'(4);
    frame_to_read = FW'(9);
    start_compare = 1'b1;
    tick();
    start_compare = 1'b0;
    k = 0;
    while (sm_start !== 1'b1 && k < 40) begin tick(); k++; end
    check("reset_test_reach_compute", sm_start, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_pulses", {start_read, new_line, sm_start, compare_done}, 0);
    check("midreset_lines_cnt", lines_cnt, 0);
    check("midreset_sm_frame", sm_frame, 0);
    repeat (3) tick();
    check("midreset_no_compare_done", cd_cnt - cd0, 0);
    check("midreset_stays_idle", busy, 0);
    run_scan(2, 4, 1'b0, 1'b0);

`ifdef OFLOW_READ_CLIENT_TIMEOUT_EN
    // Withhold sm_done: watchdog forces FINISH after TB_TIMEOUT COMPUTE cycles.
    num_of_history_frames = NHW'(1);
    start_compare = 1'b1;
    tick();
    start_compare = 1'b0;
    k = 0;
    while (sm_start !== 1'b1 && k < 40) begin tick(); k++; end
    k = 0;
    while (compare_done !== 1'b1 && k < 40) begin tick(); k++; end
    check("timeout_cycles", k, TB_TIMEOUT);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_lines_cnt", lines_cnt, 0);
    tick();
    check("timeout_idle", busy, 0);
    check("timeout_err_sticky", timeout_err, 1);
    run_scan(1, 1, 1'b1, 1'b0);
`endif

    // Randomized scans against the line-count model.
    for (int s = 0; s < 12; s++) begin
      run_scan($urandom_range(1, 6), $urandom_range(1, (1 << NHW) - 1),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("pulses_mutually_exclusive", excl_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
